// File: rtl/mem_lsu_pkg.sv
// Shared op encodings, FSM state type and lane helpers for the MEM-stage load/store unit.
// Optional misaligned-access trap is enabled by defining LSU_MISALIGN_TRAP_EN.
package mem_lsu_pkg;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_e;

    // Word ops ignore both low bits, half ops ignore bit 0.
    function automatic logic [1:0] align_lane(input logic [2:0] op, input logic [1:0] lane);
        logic [1:0] aligned;
        aligned = lane;
        if (op == OP_LW || op == OP_SW) begin
            aligned = 2'b00;
        end else if (op == OP_LH || op == OP_LHU || op == OP_SH) begin
            aligned = {lane[1], 1'b0};
        end
        return aligned;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        if (op == OP_LW || op == OP_SW) begin
            bad = (lane != 2'b00);
        end else if (op == OP_LH || op == OP_LHU || op == OP_SH) begin
            bad = lane[0];
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_lsu_lane.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
// Stays identical whether or not LSU_MISALIGN_TRAP_EN is defined.
module mem_lsu_lane
    import mem_lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2:0]        i_op,
    input  logic [1:0]        i_lane,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_load_data,
    output logic [DATA_W-1:0] o_merge_data
);

    logic [HALF_W-1:0] w_half;
    logic [BYTE_W-1:0] w_byte;

    always_comb begin
        w_half = i_rdata[{i_lane[1], 4'd0} +: HALF_W];
        w_byte = i_rdata[{i_lane, 3'd0} +: BYTE_W];

        o_load_data = i_rdata;
        unique case (i_op)
            OP_LH:   o_load_data = {{(DATA_W-HALF_W){w_half[HALF_W-1]}}, w_half};
            OP_LHU:  o_load_data = {{(DATA_W-HALF_W){1'b0}}, w_half};
            OP_LB:   o_load_data = {{(DATA_W-BYTE_W){w_byte[BYTE_W-1]}}, w_byte};
            OP_LBU:  o_load_data = {{(DATA_W-BYTE_W){1'b0}}, w_byte};
            default: o_load_data = i_rdata;
        endcase
    end

    // Memory is word-write only, so sub-word stores rewrite the old word with one lane replaced.
    always_comb begin
        o_merge_data = i_wdata;
        if (i_op == OP_SH) begin
            o_merge_data = i_rdata;
            o_merge_data[{i_lane[1], 4'd0} +: HALF_W] = i_wdata[HALF_W-1:0];
        end else if (i_op == OP_SB) begin
            o_merge_data = i_rdata;
            o_merge_data[{i_lane, 3'd0} +: BYTE_W] = i_wdata[BYTE_W-1:0];
        end
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit in front of a word-write-only data memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              err,
    output logic [31:0]       err_addr
);

    state_e              r_state;
    state_e              w_state_next;
    logic [ADDR_W-1:0]   r_index;
    logic [1:0]          r_lane;
    logic [2:0]          r_op;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_wb_valid;
    logic [4:0]          r_wb_rd;
    logic [DATA_W-1:0]   r_wb_data;

    logic [ADDR_W-1:0]   w_index;
    logic [1:0]          w_lane;
    logic                w_misalign;
    logic                w_is_load;
    logic                w_is_sw;
    logic                w_is_sub;
    logic                w_ready;
    logic                w_accept;
    logic                w_in_merge;
    logic [DATA_W-1:0]   w_load_data;
    logic [DATA_W-1:0]   w_merge_data;
    logic                w_unused;

    assign w_index   = req_addr[ADDR_W+1:2];
    assign w_lane    = align_lane(req_op, req_addr[1:0]);
    assign w_is_load = (req_op <= OP_LBU);
    assign w_is_sw   = (req_op == OP_SW);
    assign w_is_sub  = (req_op == OP_SH) || (req_op == OP_SB);
    assign w_in_merge = (r_state == MERGE);
    assign w_ready   = (r_state == IDLE) && !(r_wb_valid && !wb_ready);
    assign w_accept  = req_valid && w_ready;
    assign w_unused  = ^req_addr[31:ADDR_W+2];

    assign req_ready = w_ready;
    assign wb_valid  = r_wb_valid;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;

    mem_lsu_lane #(
        .DATA_W (DATA_W)
    ) u_lane (
        .i_op         (w_in_merge ? r_op : req_op),
        .i_lane       (w_in_merge ? r_lane : w_lane),
        .i_rdata      (mem_dataout),
        .i_wdata      (w_in_merge ? r_wdata : req_wdata),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    always_comb begin
        w_state_next     = r_state;
        mem_write_enable = 1'b0;
        mem_addr         = w_index;
        mem_datain       = req_wdata;
        unique case (r_state)
            IDLE: begin
                if (w_accept && !w_misalign) begin
                    mem_write_enable = w_is_sw;
                    if (w_is_sub) begin
                        w_state_next = MERGE;
                    end
                end
            end
            MERGE: begin
                mem_addr         = r_index;
                mem_datain       = w_merge_data;
                mem_write_enable = 1'b1;
                w_state_next     = IDLE;
            end
        endcase
        // Reset must block a write even mid-merge, before the flops clear.
        if (!rst_n) begin
            mem_write_enable = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_index    <= '0;
            r_lane     <= '0;
            r_op       <= '0;
            r_wdata    <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept && w_is_sub && !w_misalign) begin
                r_index <= w_index;
                r_lane  <= w_lane;
                r_op    <= req_op;
                r_wdata <= req_wdata;
            end
            if (w_accept && w_is_load && !w_misalign) begin
                r_wb_valid <= 1'b1;
                r_wb_rd    <= req_rd;
                r_wb_data  <= w_load_data;
            end else if (wb_ready) begin
                r_wb_valid <= 1'b0;
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic        r_err;
    logic [31:0] r_err_addr;

    assign w_misalign = is_misaligned(req_op, req_addr[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else begin
            r_err <= w_accept && w_misalign;
            if (w_accept && w_misalign) begin
                r_err_addr <= req_addr;
            end
        end
    end

    assign err      = r_err;
    assign err_addr = r_err_addr;
`else
    assign w_misalign = 1'b0;
    assign err        = 1'b0;
    assign err_addr   = '0;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: byte-level reference model plus directed vectors.
`timescale 1ns/1ps
module tb_mem_lsu;

    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4;
    localparam logic [2:0] SW = 3'd5, SH = 3'd6, SB = 3'd7;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid, req_ready, wb_ready, wb_valid, mem_write_enable, err;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata, mem_datain, mem_dataout, wb_data, err_addr;
    logic [4:0]  req_rd, wb_rd, mem_addr;

    logic [31:0] mem [0:31];
    bit          env_loaded;

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_rd           (req_rd),
        .mem_write_enable (mem_write_enable),
        .mem_addr         (mem_addr),
        .mem_datain       (mem_datain),
        .mem_dataout      (mem_dataout),
        .wb_valid         (wb_valid),
        .wb_ready         (wb_ready),
        .wb_rd            (wb_rd),
        .wb_data          (wb_data),
        .err              (err),
        .err_addr         (err_addr)
    );

    // Environment memory seen by the DUT.
    assign mem_dataout = mem[mem_addr];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (!env_loaded) begin
                for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
                mem[1]     <= 32'h1;
                mem[2]     <= 32'h2;
                env_loaded <= 1'b1;
            end
        end else if (mem_write_enable) begin
            mem[mem_addr] <= mem_datain;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-addressed memory of 128 bytes, ops described by size and extension.
    logic [7:0]  ref_mem [0:127];
    bit          ref_loaded;
    logic        m_wb_valid, m_merge, m_err;
    logic [31:0] m_wb_data, m_merge_wd, m_err_addr;
    logic [4:0]  m_wb_rd;
    logic [6:0]  m_merge_ea;
    int          m_merge_size;

    wire m_ready  = !m_merge && !(m_wb_valid && !wb_ready);
    wire m_accept = req_valid && m_ready;

    function automatic int op_size(input logic [2:0] op);
        if (op == LW || op == SW) return 4;
        if (op == LH || op == LHU || op == SH) return 2;
        return 1;
    endfunction

    function automatic logic [6:0] eff_addr(input logic [2:0] op, input logic [31:0] addr);
        int a = int'(addr[6:0]);
        return 7'(a - (a % op_size(op)));
    endfunction

    function automatic bit misaligned(input logic [2:0] op, input logic [31:0] addr);
        return (int'(addr[6:0]) % op_size(op)) != 0;
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] op, input logic [6:0] ea);
        logic [31:0] v = 32'h0;
        for (int k = 0; k < op_size(op); k++) v[8*k +: 8] = ref_mem[int'(ea) + k];
        if (op == LH && v[15]) v[31:16] = 16'hFFFF;
        if (op == LB && v[7])  v[31:8]  = 24'hFFFFFF;
        return v;
    endfunction

    function automatic logic [31:0] merged_word(input logic [6:0] ea, input int sz,
                                                input logic [31:0] wd);
        logic [31:0] w;
        int base = int'(ea) & ~3;
        int off  = int'(ea) & 3;
        for (int k = 0; k < 4; k++)  w[8*k +: 8] = ref_mem[base + k];
        for (int k = 0; k < sz; k++) w[8*(off + k) +: 8] = wd[8*k +: 8];
        return w;
    endfunction

    function automatic logic exp_we();
        if (m_merge) return 1'b1;
        return m_accept && req_op == SW && !(TRAP && misaligned(req_op, req_addr));
    endfunction

    function automatic logic [4:0] exp_idx();
        logic [6:0] e = m_merge ? m_merge_ea : eff_addr(req_op, req_addr);
        return e[6:2];
    endfunction

    function automatic logic [31:0] exp_wdata();
        return m_merge ? merged_word(m_merge_ea, m_merge_size, m_merge_wd) : req_wdata;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (!ref_loaded) begin
                for (int i = 0; i < 128; i++) ref_mem[i] <= 8'h0;
                ref_mem[4] <= 8'h1;
                ref_mem[8] <= 8'h2;
                ref_loaded <= 1'b1;
            end
            m_wb_valid   <= 1'b0;
            m_wb_data    <= 32'h0;
            m_wb_rd      <= 5'h0;
            m_merge      <= 1'b0;
            m_merge_ea   <= 7'h0;
            m_merge_size <= 0;
            m_merge_wd   <= 32'h0;
            m_err        <= 1'b0;
            m_err_addr   <= 32'h0;
        end else begin
            if (m_merge) begin
                for (int k = 0; k < m_merge_size; k++)
                    ref_mem[int'(m_merge_ea) + k] <= m_merge_wd[8*k +: 8];
                m_merge <= 1'b0;
            end
            m_err <= 1'b0;
            if (wb_ready) m_wb_valid <= 1'b0;
            if (m_accept) begin
                if (TRAP && misaligned(req_op, req_addr)) begin
                    m_err      <= 1'b1;
                    m_err_addr <= req_addr;
                end else if (req_op == SW) begin
                    for (int k = 0; k < 4; k++)
                        ref_mem[int'(eff_addr(req_op, req_addr)) + k] <= req_wdata[8*k +: 8];
                end else if (req_op == SH || req_op == SB) begin
                    m_merge      <= 1'b1;
                    m_merge_ea   <= eff_addr(req_op, req_addr);
                    m_merge_size <= op_size(req_op);
                    m_merge_wd   <= req_wdata;
                end else begin
                    m_wb_valid <= 1'b1;
                    m_wb_data  <= load_value(req_op, eff_addr(req_op, req_addr));
                    m_wb_rd    <= req_rd;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_we", mem_write_enable, 0);
            check("rst_wb_valid", wb_valid, 0);
            check("rst_wb_data", wb_data, 0);
            check("rst_wb_rd", wb_rd, 0);
            check("rst_err", err, 0);
            check("rst_err_addr", err_addr, 0);
        end else begin
            check("req_ready", req_ready, m_ready);
            check("mem_we", mem_write_enable, exp_we());
            if (exp_we()) begin
                check("mem_addr", mem_addr, exp_idx());
                check("mem_datain", mem_datain, exp_wdata());
            end
            check("wb_valid", wb_valid, m_wb_valid);
            if (m_wb_valid) begin
                check("wb_data", wb_data, m_wb_data);
                check("wb_rd", wb_rd, m_wb_rd);
            end
            check("err", err, m_err);
            if (m_err) check("err_addr", err_addr, m_err_addr);
        end
    end

    // Presents one op and returns #1 after the edge that accepted it.
    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd);
        int n = 0;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        req_rd    = rd;
        req_valid = 1'b1;
        while (!m_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!m_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL issue_timeout: op %0d addr %08h never accepted", op, addr);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_rd    = 5'h0;
        wb_ready  = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_wb_valid", wb_valid, 0);
        check("reset_ready_gated_we", mem_write_enable, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        issue(LW, 32'h04, 32'h0, 5'd1);
        check("lw4_valid", wb_valid, 1);
        check("lw4_data", wb_data, 32'h00000001);
        check("lw4_rd", wb_rd, 5'd1);

        issue(SW, 32'h0C, 32'hDEADBEEF, 5'd0);
        check("sw_mem3", mem[3], 32'hDEADBEEF);
        issue(LW, 32'h0C, 32'h0, 5'd2);
        check("lw_c_data", wb_data, 32'hDEADBEEF);

        issue(SB, 32'h0D, 32'h00000055, 5'd0);
        check("sb_merge_ready", req_ready, 0);
        check("sb_merge_we", mem_write_enable, 1);
        check("sb_merge_data", mem_datain, 32'hDEAD55EF);
        @(posedge clk);
        #1;
        check("sb_mem3", mem[3], 32'hDEAD55EF);
        check("sb_done_we", mem_write_enable, 0);

        issue(LB, 32'h0D, 32'h0, 5'd3);
        check("lb_d", wb_data, 32'h00000055);
        issue(LBU, 32'h0F, 32'h0, 5'd4);
        check("lbu_f", wb_data, 32'h000000DE);
        issue(LB, 32'h0F, 32'h0, 5'd5);
        check("lb_f", wb_data, 32'hFFFFFFDE);

        // Result held while MEM/WB stalls.
        issue(LW, 32'h04, 32'h0, 5'd7);
        wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid", wb_valid, 1);
            check("hold_data", wb_data, 32'h00000001);
            check("hold_rd", wb_rd, 5'd7);
            check("hold_ready", req_ready, 0);
        end
        wb_ready = 1'b1;
        #1;
        check("release_ready", req_ready, 1);
        issue(LW, 32'h08, 32'h0, 5'd8);
        check("release_data", wb_data, 32'h00000002);
        check("release_rd", wb_rd, 5'd8);

        // Reset lands while the SH merge is in flight.
        issue(SH, 32'h08, 32'h0000ABCD, 5'd0);
        #1 rst_n = 1'b0;
        #1;
        check("rmw_rst_we", mem_write_enable, 0);
        check("rmw_rst_wb_valid", wb_valid, 0);
        check("rmw_rst_wb_data", wb_data, 0);
        check("rmw_rst_err", err, 0);
        check("rmw_rst_ready", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        check("rmw_rst_mem2", mem[2], 32'h00000002);
        @(posedge clk);
        #1 rst_n = 1'b1;

        issue(SH, 32'h0A, 32'h1234ABCD, 5'd0);
        @(posedge clk);
        #1;
        check("sh_mem2", mem[2], 32'hABCD0002);
        issue(LH, 32'h0A, 32'h0, 5'd11);
        check("lh_a", wb_data, 32'hFFFFABCD);
        issue(LHU, 32'h0A, 32'h0, 5'd12);
        check("lhu_a", wb_data, 32'h0000ABCD);
        issue(LW, 32'h84, 32'h0, 5'd10);
        check("lw_wrap", wb_data, 32'h00000001);

        issue(LW, 32'h05, 32'h0, 5'd9);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_err", err, 1);
        check("mis_err_addr", err_addr, 32'h00000005);
        check("mis_no_wb", wb_valid, 0);
        @(posedge clk);
        #1;
        check("mis_err_pulse", err, 0);
`else
        check("mis_data", wb_data, 32'h00000001);
        check("mis_valid", wb_valid, 1);
        check("mis_err", err, 0);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit sitting directly upstream of the 32x32 word data memory in the MEM stage.
- Accepts one load/store per handshake from the EX/MEM register and converts byte addresses to the memory's 5-bit word index.
- Performs sub-word stores as read-modify-write over two cycles, because the memory is word-write only.
- Sign/zero-extends load data and presents a registered result to the MEM/WB register.

Parameters:
- ADDR_W, 5, word-index width driven to memory (depth 2**ADDR_W words)
- DATA_W, 32, data width; fixed at 32 for this ISA

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  EX/MEM presents a memory op
- req_ready  out  1  LSU accepts op this cycle
- req_op  in  3  0=LW 1=LH 2=LHU 3=LB 4=LBU 5=SW 6=SH 7=SB
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bits used for SH/SB)
- req_rd  in  5  load destination register
- mem_write_enable  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory word index
- mem_datain  out  32  memory write data
- mem_dataout  in  32  memory combinational read data
- wb_valid  out  1  load result valid
- wb_ready  in  1  MEM/WB can take result
- wb_rd  out  5  load destination
- wb_data  out  32  extended load data
- err  out  1  misaligned-access pulse
- err_addr  out  32  faulting byte address

Behaviour:
- Reset (async, rst_n=0): state IDLE; wb_valid=0, wb_rd=0, wb_data=0, err=0, err_addr=0; latched RMW registers cleared; mem_write_enable=0 combinationally while rst_n=0.
- Word index = req_addr[6:2]; upper address bits are ignored (wrap modulo 128 bytes).
- req_ready = (state==IDLE) && !(wb_valid && !wb_ready).
- Accept = req_valid && req_ready.
- FSM states: IDLE, MERGE.
- IDLE, accepted load: mem_addr = index this cycle. Extract lane from mem_dataout per req_addr[1:0] (LH lane = addr[1]). Sign- or zero-extend. Register into wb_data/wb_rd with wb_valid=1 next edge. Latency 1.
- IDLE, accepted SW: mem_write_enable=1, mem_datain=req_wdata in the same cycle; write lands at that edge. No wb output.
- IDLE, accepted SH/SB: latch index, lane, op and data; go to MERGE.
- MERGE: mem_addr = latched index. mem_datain = mem_dataout with only the target byte/half replaced. mem_write_enable=1. req_ready=0. Return to IDLE next edge. Total 2 cycles; the upstream stage stalls one cycle.
- wb_valid holds, with wb_data/wb_rd stable, until wb_ready=1. While it holds, req_ready=0.
- Accept and consume in the same cycle is allowed: a new load result replaces the old one with wb_valid staying 1.
- mem_write_enable is never 1 outside an accepted SW or the MERGE state.
- Reset asserted during MERGE: write suppressed, state returns to IDLE, latched data discarded.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]=1, are accepted but cause no memory access and no wb_valid. err pulses 1 cycle and err_addr = req_addr.
- Undefined: low address bits are forced aligned (word ops ignore [1:0], half ops ignore [0]); err and err_addr are tied 0.

Decomposition:
- Shared package mem_lsu_pkg: op encodings (OP_LW..OP_SB), state enum {IDLE, MERGE}, helper constants for lane widths.
- One sub-module, mem_lsu_lane, purely combinational:
  - extract+extend for loads;
  - merge for sub-word stores.
  - Instantiated once; the FSM lives in mem_lsu.

Test Plan:
- Memory preloaded word1=0x00000001, word2=0x00000002. LW addr 0x04 -> next cycle wb_valid=1, wb_data=0x00000001; mem_write_enable never 1.
- SW addr 0x0C data 0xDEADBEEF, then LW 0x0C -> wb_data=0xDEADBEEF.
- Word3=0xDEADBEEF. SB addr 0x0D data 0x55 -> req_ready=0 for 1 cycle, single write of 0xDEAD55EF. Then LB 0x0D -> 0x00000055; LBU 0x0F -> 0x000000DE; LB 0x0F -> 0xFFFFFFDE.
- Hold wb_ready=0 after a load: wb_valid/wb_data stable and req_ready=0 for 3 cycles. Raise wb_ready -> next op accepted that cycle.
- Assert rst_n=0 during MERGE of SH addr 0x08 data 0xABCD -> word2 stays 0x00000002, all outputs 0, state IDLE.
- With LSU_MISALIGN_TRAP_EN: LW addr 0x05 -> err=1 one cycle, err_addr=0x00000005, no wb_valid. Without the macro: same op -> wb_data=0x00000001, err=0.
